// File: rtl/lpc_mem_bridge_pkg.sv
// Shared definitions for the CPU-to-LPC memory bridge.
//   state_e          : bridge FSM states
//   SIZE_*           : req_size encodings (2'b11 behaves like SIZE_WORD)
//   DEFAULT_TIMEOUT  : default per-phase handshake wait limit in lclk cycles
//   size_last        : maps a size code to the index of the final byte
package lpc_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CLEAR = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  // Index of the last byte to move: N-1 for N = 1, 2 or 4.
  function automatic logic [1:0] size_last(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_last = 2'd0;
      SIZE_HALF: size_last = 2'd1;
      default:   size_last = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lpc_mem_bridge.sv
// Bridges single CPU load/store requests onto a byte-wide LPC host master,
// splitting half/word accesses into sequential byte cycles (little-endian).
// Ports:
//   lclk, lreset_n                    clock, async active-low reset
//   req_valid/req_ready/req_we/
//   req_size/req_addr/req_wdata       CPU request channel
//   rsp_valid/rsp_rdata/rsp_err       one-cycle completion (no backpressure)
//   lpc_go/lpc_dir/lpc_addr/
//   lpc_wdata/lpc_rdata/lpc_done      four-phase handshake to the LPC master
// Every output is a flop; each output's next value is derived from the
// next state so it lines up with the state it belongs to.
module lpc_mem_bridge
  import lpc_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        lclk,
  input  logic        lreset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        lpc_go,
  output logic        lpc_dir,
  output logic [31:0] lpc_addr,
  output logic [7:0]  lpc_wdata,
  input  logic [7:0]  lpc_rdata,
  input  logic        lpc_done
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Abort when the wait counter would reach TIMEOUT on this cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_q, last_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic          go_q, go_d;
  logic          dir_q, dir_d;
  logic [31:0]   laddr_q, laddr_d;
  logic [7:0]    lwdata_q, lwdata_d;

  logic [1:0]    idx_nxt;

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      go_q        <= 1'b0;
      dir_q       <= 1'b0;
      laddr_q     <= '0;
      lwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      go_q        <= go_d;
      dir_q       <= dir_d;
      laddr_q     <= laddr_d;
      lwdata_q    <= lwdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    go_d        = go_q;
    dir_d       = dir_q;
    laddr_d     = laddr_q;
    lwdata_d    = lwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    idx_nxt     = idx_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        // req_ready_q gates acceptance so the first cycle after reset
        // release (ready still low) cannot take a request.
        if (req_valid && req_ready_q) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          last_d   = size_last(req_size);
          idx_d    = '0;
          acc_d    = '0;
          cnt_d    = '0;
          go_d     = 1'b1;
          dir_d    = req_we;
          laddr_d  = req_addr;
          lwdata_d = req_wdata[7:0];
          state_d  = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (lpc_done) begin
          if (!we_q) begin
            acc_d[{idx_q, 3'b000} +: 8] = lpc_rdata;
          end
          go_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else if (cnt_q == CNT_LAST) begin
          go_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_CLEAR: begin
        if (!lpc_done) begin
          if (idx_q == last_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? '0 : acc_q;
            state_d     = ST_RESP;
          end else begin
            idx_d    = idx_nxt;
            cnt_d    = '0;
            go_d     = 1'b1;
            laddr_d  = addr_q + {30'd0, idx_nxt};
            lwdata_d = wdata_q[{idx_nxt, 3'b000} +: 8];
            state_d  = ST_ISSUE;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign lpc_go    = go_q;
  assign lpc_dir   = dir_q;
  assign lpc_addr  = laddr_q;
  assign lpc_wdata = lwdata_q;

endmodule

// File: tb/tb_lpc_mem_bridge.sv
// Directed self-checking bench for lpc_mem_bridge with a behavioural LPC
// master: done follows go combinationally, read bytes come from a small
// table indexed by the byte position within the current request.
module tb_lpc_mem_bridge;

  logic        lclk;
  logic        lreset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        lpc_go;
  logic        lpc_dir;
  logic [31:0] lpc_addr;
  logic [7:0]  lpc_wdata;
  logic [7:0]  lpc_rdata;
  logic        lpc_done;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // LPC master model state
  logic [7:0]  rd_bytes [4];
  int unsigned xfer_n = 0;
  int unsigned xfer_base = 0;
  int unsigned rel;
  logic        stall_en = 1'b0;
  int unsigned stall_rel = 0;
  logic        force_done = 1'b0;
  int unsigned rsp_cnt = 0;
  int unsigned stall_cyc = 0;
  logic [31:0] log_addr [64];
  logic        log_dir [64];
  logic [7:0]  log_wd [64];

  lpc_mem_bridge #(.TIMEOUT(8)) dut (
    .lclk      (lclk),
    .lreset_n  (lreset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .lpc_go    (lpc_go),
    .lpc_dir   (lpc_dir),
    .lpc_addr  (lpc_addr),
    .lpc_wdata (lpc_wdata),
    .lpc_rdata (lpc_rdata),
    .lpc_done  (lpc_done)
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  assign rel       = xfer_n - xfer_base;
  assign lpc_rdata = rd_bytes[rel[1:0]];
  assign lpc_done  = force_done || (lpc_go && !(stall_en && rel == stall_rel));

  always @(posedge lclk) begin
    if (lreset_n) begin
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (lpc_go && !lpc_done) stall_cyc <= stall_cyc + 1;
      if (lpc_go && lpc_done) begin
        log_addr[xfer_n % 64] <= lpc_addr;
        log_dir[xfer_n % 64]  <= lpc_dir;
        log_wd[xfer_n % 64]   <= lpc_wdata;
        xfer_n <= xfer_n + 1;
      end
    end
  end

  // Issues one request and waits for its response; lat counts falling
  // edges after the accepting edge, so a minimal N-byte access gives 2N+1.
  task automatic run_req(input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int unsigned lat, output logic ok);
    int unsigned n;
    @(negedge lclk);
    xfer_base = xfer_n;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge lclk);
      n++;
    end
    @(posedge lclk);
    @(negedge lclk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      @(negedge lclk);
      lat++;
    end
    ok = rsp_valid;
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic test_reset;
    lreset_n = 1'b1;
    #1 lreset_n = 1'b0;
    repeat (3) @(negedge lclk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, lpc_go, lpc_dir} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000", {req_ready, rsp_valid, rsp_err, lpc_go, lpc_dir});
    end
    n_cmp++;
    if ({rsp_rdata, lpc_addr, lpc_wdata} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {rsp_rdata, lpc_addr, lpc_wdata});
    end
    #2 lreset_n = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready_pre: got %b want 0", req_ready);
    end
    @(negedge lclk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready_post: got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_load;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat, b;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'h000F_FFFC; exp_a[1] = 32'h000F_FFFD;
    exp_a[2] = 32'h000F_FFFE; exp_a[3] = 32'h000F_FFFF;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    run_req(1'b0, 2'b10, 32'h000F_FFFC, 32'h0, rd, er, lat, ok);
    b = xfer_base;
    n_cmp++;
    if (!ok || rd !== 32'h4433_2211 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL word_load_rsp: got ok=%b rdata=%h err=%b want ok=1 rdata=44332211 err=0", ok, rd, er);
    end
    n_cmp++;
    if (lat != 9) begin
      n_bad++;
      $display("FAIL word_load_latency: got %0d want 9", lat);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      n_cmp++;
      if (log_addr[(b + k) % 64] !== exp_a[k] || log_dir[(b + k) % 64] !== 1'b0) begin
        n_bad++;
        $display("FAIL word_load_addr%0d: got %h dir=%b want %h dir=0", k, log_addr[(b + k) % 64], log_dir[(b + k) % 64], exp_a[k]);
      end
    end
    @(negedge lclk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL word_load_after: got valid=%b ready=%b want valid=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_half_store;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat, b;
    run_req(1'b1, 2'b01, 32'h0000_1000, 32'hAABB_CCDD, rd, er, lat, ok);
    b = xfer_base;
    n_cmp++;
    if (!ok || rd !== 32'h0 || er !== 1'b0 || lat != 5) begin
      n_bad++;
      $display("FAIL half_store_rsp: got ok=%b rdata=%h err=%b lat=%0d want 1 00000000 0 5", ok, rd, er, lat);
    end
    n_cmp++;
    if (xfer_n - b != 2) begin
      n_bad++;
      $display("FAIL half_store_count: got %0d want 2", xfer_n - b);
    end
    n_cmp++;
    if (log_addr[b % 64] !== 32'h1000 || log_wd[b % 64] !== 8'hDD || log_dir[b % 64] !== 1'b1) begin
      n_bad++;
      $display("FAIL half_store_b0: got %h/%h/%b want 00001000/dd/1", log_addr[b % 64], log_wd[b % 64], log_dir[b % 64]);
    end
    n_cmp++;
    if (log_addr[(b + 1) % 64] !== 32'h1001 || log_wd[(b + 1) % 64] !== 8'hCC || log_dir[(b + 1) % 64] !== 1'b1) begin
      n_bad++;
      $display("FAIL half_store_b1: got %h/%h/%b want 00001001/cc/1", log_addr[(b + 1) % 64], log_wd[(b + 1) % 64], log_dir[(b + 1) % 64]);
    end
  endtask

  task automatic test_byte_load;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat;
    rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hEE; rd_bytes[2] = 8'hEE; rd_bytes[3] = 8'hEE;
    run_req(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || rd !== 32'h0000_005A || er !== 1'b0 || lat != 3) begin
      n_bad++;
      $display("FAIL byte_load_rsp: got ok=%b rdata=%h err=%b lat=%0d want 1 0000005a 0 3", ok, rd, er, lat);
    end
    n_cmp++;
    if (xfer_n - xfer_base != 1 || log_addr[xfer_base % 64] !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL byte_load_addr: got n=%0d addr=%h want 1 ffffffff", xfer_n - xfer_base, log_addr[xfer_base % 64]);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat, b;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF;
    exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
    rd_bytes[0] = 8'hA1; rd_bytes[1] = 8'hB2; rd_bytes[2] = 8'hC3; rd_bytes[3] = 8'hD4;
    // size code 11 must behave as a word
    run_req(1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0, rd, er, lat, ok);
    b = xfer_base;
    n_cmp++;
    if (!ok || rd !== 32'hD4C3_B2A1 || er !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_rsp: got ok=%b rdata=%h err=%b want 1 d4c3b2a1 0", ok, rd, er);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      n_cmp++;
      if (log_addr[(b + k) % 64] !== exp_a[k]) begin
        n_bad++;
        $display("FAIL wrap_addr%0d: got %h want %h", k, log_addr[(b + k) % 64], exp_a[k]);
      end
    end
  endtask

  task automatic test_idle_done;
    int unsigned r0, x0;
    @(negedge lclk);
    r0 = rsp_cnt;
    x0 = xfer_n;
    force_done = 1'b1;
    repeat (5) @(negedge lclk);
    n_cmp++;
    if (rsp_cnt != r0 || xfer_n != x0 || lpc_go !== 1'b0 || req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL idle_done: got rsp=%0d xfer=%0d go=%b ready=%b want rsp=%0d xfer=%0d go=0 ready=1", rsp_cnt, xfer_n, lpc_go, req_ready, r0, x0);
    end
    force_done = 1'b0;
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat, s0;
    rd_bytes[0] = 8'h01; rd_bytes[1] = 8'h02; rd_bytes[2] = 8'h03; rd_bytes[3] = 8'h04;
    stall_en  = 1'b1;
    stall_rel = 2;
    s0 = stall_cyc;
    run_req(1'b0, 2'b10, 32'h0000_2000, 32'h0, rd, er, lat, ok);
    n_cmp++;
    if (!ok || rd !== 32'hFFFF_FFFF || er !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_rsp: got ok=%b rdata=%h err=%b want 1 ffffffff 1", ok, rd, er);
    end
    n_cmp++;
    if (stall_cyc - s0 != 8 || lpc_go !== 1'b0 || lat != 13) begin
      n_bad++;
      $display("FAIL timeout_wait: got wait=%0d go=%b lat=%0d want 8 0 13", stall_cyc - s0, lpc_go, lat);
    end
    n_cmp++;
    if (xfer_n - xfer_base != 2) begin
      n_bad++;
      $display("FAIL timeout_count: got %0d want 2", xfer_n - xfer_base);
    end
    @(negedge lclk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_after: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [31:0] rd;
    logic er, ok;
    int unsigned lat, r0, b;
    @(negedge lclk);
    xfer_base = xfer_n;
    stall_en  = 1'b1;
    stall_rel = 1;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h0000_3000; req_wdata = 32'h1234_5678;
    @(posedge lclk);
    @(negedge lclk);
    req_valid = 1'b0;
    repeat (3) @(negedge lclk);
    n_cmp++;
    if (lpc_go !== 1'b1 || lpc_addr !== 32'h0000_3001) begin
      n_bad++;
      $display("FAIL mid_reset_pre: got go=%b addr=%h want 1 00003001", lpc_go, lpc_addr);
    end
    #2 lreset_n = 1'b0;
    #1;
    n_cmp++;
    if (lpc_go !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_async: got go=%b ready=%b valid=%b want 0 0 0", lpc_go, req_ready, rsp_valid);
    end
    @(negedge lclk);
    #2 lreset_n = 1'b1;
    stall_en = 1'b0;
    repeat (4) @(negedge lclk);
    n_cmp++;
    if (rsp_cnt != r0 || req_ready !== 1'b1 || lpc_go !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_reset_quiet: got rsp=%0d ready=%b go=%b want %0d 1 0", rsp_cnt, req_ready, lpc_go, r0);
    end
    run_req(1'b1, 2'b10, 32'h0000_4000, 32'hCAFE_F00D, rd, er, lat, ok);
    b = xfer_base;
    n_cmp++;
    if (!ok || rd !== 32'h0 || er !== 1'b0 || lat != 9 || xfer_n - b != 4) begin
      n_bad++;
      $display("FAIL mid_reset_next: got ok=%b rdata=%h err=%b lat=%0d n=%0d want 1 0 0 9 4", ok, rd, er, lat, xfer_n - b);
    end
    n_cmp++;
    if (log_wd[b % 64] !== 8'h0D || log_wd[(b + 3) % 64] !== 8'hCA || log_addr[(b + 3) % 64] !== 32'h0000_4003) begin
      n_bad++;
      $display("FAIL mid_reset_data: got %h %h %h want 0d ca 00004003", log_wd[b % 64], log_wd[(b + 3) % 64], log_addr[(b + 3) % 64]);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned lat, seen, r0;
    int unsigned lat_r [2];
    logic rdy_r [2];
    rd_bytes[0] = 8'h77; rd_bytes[1] = 8'h00; rd_bytes[2] = 8'h00; rd_bytes[3] = 8'h00;
    @(negedge lclk);
    xfer_base = xfer_n;
    r0 = rsp_cnt;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00;
    req_addr = 32'h0000_0050; req_wdata = 32'h0;
    @(posedge lclk);
    seen = 0;
    lat = 0;
    lat_r[0] = 0; lat_r[1] = 0; rdy_r[0] = 1'b1; rdy_r[1] = 1'b1;
    while (seen < 2 && lat < 60) begin
      @(negedge lclk);
      lat++;
      if (rsp_valid) begin
        lat_r[seen] = lat;
        rdy_r[seen] = req_ready;
        seen++;
      end
    end
    req_valid = 1'b0;
    n_cmp++;
    if (seen != 2 || lat_r[0] != 3 || lat_r[1] != 7) begin
      n_bad++;
      $display("FAIL b2b_timing: got n=%0d lat=%0d,%0d want 2 3,7", seen, lat_r[0], lat_r[1]);
    end
    n_cmp++;
    if (rdy_r[0] !== 1'b0 || rdy_r[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_ready_in_resp: got %b%b want 00", rdy_r[0], rdy_r[1]);
    end
    repeat (3) @(negedge lclk);
    n_cmp++;
    if (rsp_cnt - r0 != 2 || xfer_n - xfer_base != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got rsp=%0d xfer=%0d want 2 2", rsp_cnt - r0, xfer_n - xfer_base);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;
    test_reset();
    test_word_load();
    test_half_store();
    test_byte_load();
    test_wrap();
    test_idle_done();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
